// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared types and defaults for the shift-and-add multiplier controller.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mult_state_t;

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Request/result bundle between a requesting master and the multiplier controller.
interface shift_add_mult_ctrl_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic               start_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] product_o;

  modport master (
    output start_i, a_i, b_i,
    input  busy_o, done_o, product_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output busy_o, done_o, product_o
  );

endinterface

// File: rtl/shift_add_mult_ctrl_rca_adder.sv
// Full-adder cell and the WIDTH-bit ripple-carry adder built from a chain of them.
module carry_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module rca_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    carry_adder u_cell (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry[i]),
      .s_o (s_o[i]),
      .c_o (carry[i+1])
    );
  end

  assign c_o = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier: one ripple-carry adder reused over WIDTH
// cycles, with a start/done handshake and a held product register.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  shift_add_mult_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  mult_state_t        state_q,   state_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic [WIDTH-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0]   mplr_q,    mplr_d;
  logic [WIDTH-1:0]   acc_q,     acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] stepResult;

  assign addend = mplr_q[0] ? mcand_q : '0;

  rca_adder #(.WIDTH(WIDTH)) u_adder (
    .a_i (acc_q),
    .b_i (addend),
    .c_i (1'b0),
    .s_o (sum),
    .c_o (carry)
  );

  // The adder carry becomes the new accumulator MSB as {acc, mplr} shifts right.
  assign stepResult = {carry, sum, mplr_q[WIDTH-1:1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    product_d = product_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          state_d = CALC;
          mcand_d = bus.a_i;
          mplr_d  = bus.b_i;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        {acc_d, mplr_d} = stepResult;
        // The counter parks on its last value so it never wraps past WIDTH-1.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = DONE;
          product_d = stepResult;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o    = (state_q == CALC);
  assign bus.done_o    = (state_q == DONE);
  assign bus.product_o = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed and random checks of the shift-and-add multiplier controller at WIDTH=8.
module tb_shift_add_mult_ctrl;

  localparam int WIDTH = 8;
  localparam int MAX_WAIT = 20;

  logic clk;
  logic rst;
  int   testCount;
  int   failCount;

  shift_add_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

  shift_add_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns just after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    tick();
    bus.start_i = 1'b0;
    bus.a_i     = ~a;
    bus.b_i     = ~b;
  endtask

  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit midPulse);
    logic [2*WIDTH-1:0] expected;
    int  cycles;
    bit  doneSeen;
    expected = 16'(a) * 16'(b);
    applyStimulus(a, b);
    checkOutput("busyAfterStart", 32'(bus.busy_o), 32'd1);
    cycles   = 0;
    doneSeen = 1'b0;
    while (!doneSeen && cycles < MAX_WAIT) begin
      if (midPulse && cycles == 3) begin
        bus.start_i = 1'b1;
        bus.a_i     = 8'hFF;
        bus.b_i     = 8'hFF;
      end else begin
        bus.start_i = 1'b0;
      end
      tick();
      cycles++;
      doneSeen = bus.done_o;
    end
    bus.start_i = 1'b0;
    checkOutput("latency", 32'(cycles), 32'(WIDTH));
    checkOutput("product", 32'(bus.product_o), 32'(expected));
    tick();
    checkOutput("donePulseWidth", 32'(bus.done_o), 32'd0);
    checkOutput("productHold", 32'(bus.product_o), 32'(expected));
    checkOutput("busyIdle", 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    int  cycles;
    bit  doneSeen;
    bit  busyGap;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    testCount   = 0;
    failCount   = 0;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    repeat (2) tick();
    checkOutput("resetBusy", 32'(bus.busy_o), 32'd0);
    checkOutput("resetDone", 32'(bus.done_o), 32'd0);
    checkOutput("resetProduct", 32'(bus.product_o), 32'd0);
    rst = 1'b0;
    tick();

    runOp(8'h0F, 8'h0F, 1'b0);
    runOp(8'hFF, 8'hFF, 1'b0);
    runOp(8'h00, 8'hA5, 1'b0);
    runOp(8'h01, 8'hA5, 1'b0);

    // Start held high: the second request is taken straight out of DONE.
    bus.start_i = 1'b1;
    bus.a_i     = 8'd3;
    bus.b_i     = 8'd5;
    tick();
    checkOutput("b2bBusy", 32'(bus.busy_o), 32'd1);
    cycles = 0; doneSeen = 1'b0; busyGap = 1'b0;
    while (!doneSeen && cycles < MAX_WAIT) begin
      tick();
      cycles++;
      doneSeen = bus.done_o;
      if (!bus.done_o && !bus.busy_o) busyGap = 1'b1;
    end
    checkOutput("b2bLatency1", 32'(cycles), 32'(WIDTH));
    checkOutput("b2bProduct1", 32'(bus.product_o), 32'h000F);
    checkOutput("b2bBusyInDone", 32'(bus.busy_o), 32'd0);
    bus.a_i = 8'd7;
    bus.b_i = 8'd9;
    cycles = 0; doneSeen = 1'b0;
    while (!doneSeen && cycles < MAX_WAIT) begin
      tick();
      cycles++;
      doneSeen = bus.done_o;
      if (!bus.done_o && !bus.busy_o) busyGap = 1'b1;
    end
    bus.start_i = 1'b0;
    checkOutput("b2bPeriod", 32'(cycles), 32'(WIDTH + 1));
    checkOutput("b2bProduct2", 32'(bus.product_o), 32'h003F);
    checkOutput("b2bBusyGap", 32'(busyGap), 32'd0);
    tick();
    checkOutput("b2bIdle", 32'(bus.busy_o | bus.done_o), 32'd0);

    // A start pulse in the middle of a calculation must not disturb it.
    runOp(8'h12, 8'h34, 1'b1);

    // Reset part-way through a calculation aborts it with no completion.
    applyStimulus(8'hFF, 8'hFF);
    repeat (3) tick();
    checkOutput("abortBusyBefore", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("abortBusy", 32'(bus.busy_o), 32'd0);
    checkOutput("abortDone", 32'(bus.done_o), 32'd0);
    checkOutput("abortProduct", 32'(bus.product_o), 32'd0);
    rst = 1'b0;
    doneSeen = 1'b0;
    repeat (12) begin
      tick();
      if (bus.done_o) doneSeen = 1'b1;
    end
    checkOutput("abortNoDone", 32'(doneSeen), 32'd0);
    runOp(8'h0A, 8'h0B, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      runOp(ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
